multicycle_controller: RTL and testbench

Multicycle sequencing controller for the RISC-V datapath: a registered FSM that walks each instruction through FETCH, DECODE, EXEC, MEM and WB, producing every datapath strobe and mux select. It replaces the single-cycle combinational `Control` path, so one shared memory port and one ALU can be reused across cycles. It handles variable-latency memory through a ready handshake and halts cleanly on an illegal or undefined opcode.

---
 rtl/riscv_ctrl_pkg.sv | 29 ++
 rtl/mc_perf_counters.sv | 29 ++
 rtl/multicycle_controller.sv | 158 +++++++++++++++
 tb/tb_multicycle_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V sequencing controller:
// FSM states, major opcodes, ALU operation and ALU B-source selects.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_ITYPE = 3'b011;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/mc_perf_counters.sv
// Cycle and retired-instruction counters for the multicycle controller.
// Both wrap modulo 2^32 and freeze while the core is halted.
module mc_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        halted,
  input  logic        retire,
  output logic [31:0] cycle_count,
  output logic [31:0] instret
);

  logic [31:0] cycle_q;
  logic [31:0] instret_q;

  // count live cycles and retirements, cleared by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (!halted) cycle_q <= cycle_q + 32'd1;
      if (retire)  instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_count = cycle_q;
  assign instret     = instret_q;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RISC-V datapath.
// Define MC_PERF_COUNTERS_EN to add the cycle_count/instret outputs.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        mem_to_reg,
  output logic        pc_src,
  output logic        halted,
  output logic [2:0]  state
`ifdef MC_PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret
`endif
);

  state_e state_q;
  state_e state_d;

  // next-state: X/Z or unknown opcodes and illegal codes fall into HALT
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R, OP_IALU, OP_LOAD,
          OP_STORE, OP_BRANCH: state_d = S_EXEC;
          default:             state_d = S_HALT;
        endcase
      end
      S_EXEC: begin
        case (opcode)
          OP_R, OP_IALU:     state_d = S_WB;
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BRANCH:         state_d = S_FETCH;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        case (opcode)
          OP_LOAD:  if (mem_ready) state_d = S_WB;
          OP_STORE: if (mem_ready) state_d = S_FETCH;
          default:  state_d = S_HALT;
        endcase
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // state register, forced to FETCH asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // strobes decoded from state/opcode, gated by reset so nothing writes
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM;
      S_EXEC: begin
        alu_src_a = 1'b1;
        case (opcode)
          OP_R:    alu_op = ALU_RTYPE;
          OP_IALU: begin
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_ITYPE;
          end
          OP_LOAD, OP_STORE: alu_src_b = SRCB_IMM;
          OP_BRANCH: begin
            alu_op   = ALU_SUB;
            pc_src   = 1'b1;
            pc_write = zero;
          end
          default: alu_src_a = 1'b1;
        endcase
      end
      S_MEM: begin
        mem_read  = (opcode == OP_LOAD);
        mem_write = (opcode == OP_STORE);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LOAD);
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALU_ADD;
      mem_to_reg = 1'b0;
      pc_src     = 1'b0;
      halted     = 1'b0;
    end
  end

  assign state = state_q;

`ifdef MC_PERF_COUNTERS_EN
  logic retire;
  logic halt_next;

  // the decode cycle that discovers an illegal opcode is not counted
  assign halt_next = (state_d == S_HALT);
  assign retire = (state_q == S_WB)
               || (state_q == S_MEM && opcode == OP_STORE && mem_ready)
               || (state_q == S_EXEC && opcode == OP_BRANCH);

  mc_perf_counters u_perf (
    .clk         (clk),
    .reset       (reset),
    .halted      (halt_next),
    .retire      (retire),
    .cycle_count (cycle_count),
    .instret     (instret)
  );
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller.
// Counter checks compile in when MC_PERF_COUNTERS_EN is defined.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, reg_write;
  logic        mem_read, mem_write, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic        mem_to_reg, pc_src, halted;
  logic [2:0]  state;
`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] cycle_count, instret;
`endif

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .mem_to_reg (mem_to_reg),
    .pc_src     (pc_src),
    .halted     (halted),
    .state      (state)
`ifdef MC_PERF_COUNTERS_EN
    ,
    .cycle_count(cycle_count),
    .instret    (instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_rst;
    logic [6:0]  op;
    logic        z;
    logic        rdy;
    logic [16:0] exp;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t prog[$];
  vec_t misc[$];

  localparam logic [6:0] OP_BAD = 7'b1111111;

  // {state,pcw,irw,rw,mr,mw,srca,srcb,aluop,m2r,pcsrc,halted}
  function automatic logic [16:0] e(
    input logic [2:0] st, input logic pcw, input logic irw,
    input logic rw, input logic mr, input logic mw,
    input logic sa, input logic [1:0] sb, input logic [2:0] aop,
    input logic m2r, input logic ps, input logic h);
    return {st, pcw, irw, rw, mr, mw, sa, sb, aop, m2r, ps, h};
  endfunction

  function automatic logic [16:0] act();
    return {state, pc_write, ir_write, reg_write, mem_read,
            mem_write, alu_src_a, alu_src_b, alu_op,
            mem_to_reg, pc_src, halted};
  endfunction

  function automatic logic [16:0] x_fetch(input logic r);
    return e(3'd0, r, r, 0, 1, 0, 0, 2'b01, 3'b000, 0, 0, 0);
  endfunction
  function automatic logic [16:0] x_dec();
    return e(3'd1, 0, 0, 0, 0, 0, 0, 2'b10, 3'b000, 0, 0, 0);
  endfunction
  function automatic logic [16:0] x_ex(
    input logic [1:0] sb, input logic [2:0] aop);
    return e(3'd2, 0, 0, 0, 0, 0, 1, sb, aop, 0, 0, 0);
  endfunction
  function automatic logic [16:0] x_beq(input logic z);
    return e(3'd2, z, 0, 0, 0, 0, 1, 2'b00, 3'b001, 0, 1, 0);
  endfunction
  function automatic logic [16:0] x_mem(input logic rd);
    return e(3'd3, 0, 0, 0, rd, !rd, 0, 2'b00, 3'b000, 0, 0, 0);
  endfunction
  function automatic logic [16:0] x_wb(input logic m);
    return e(3'd4, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, m, 0, 0);
  endfunction
  function automatic logic [16:0] x_halt();
    return e(3'd5, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 1);
  endfunction

  function automatic vec_t mk(input logic r, input logic [6:0] op,
    input logic z, input logic rdy, input logic [16:0] ex);
    vec_t v;
    v.do_rst = r; v.op = op; v.z = z; v.rdy = rdy; v.exp = ex;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // entered at posedge+1; leaves at posedge+1 with reset released
  task automatic do_reset();
    reset = 1'b1;
    #1 check("reset_outputs", {15'd0, act()}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string nm);
    if (v.do_rst) do_reset();
    opcode = v.op; zero = v.z; mem_ready = v.rdy;
    @(negedge clk);
    check(nm, {15'd0, act()}, {15'd0, v.exp});
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; opcode = OP_R; zero = 0; mem_ready = 0;

    // add, lw, sw, beq(taken) with mem_ready=1, then an illegal op
    prog.push_back(mk(1, OP_R, 1, 1, x_fetch(1)));
    prog.push_back(mk(0, OP_R, 1, 1, x_dec()));
    prog.push_back(mk(0, OP_R, 1, 1, x_ex(2'b00, 3'b010)));
    prog.push_back(mk(0, OP_R, 1, 1, x_wb(0)));
    prog.push_back(mk(0, OP_LOAD, 1, 1, x_fetch(1)));
    prog.push_back(mk(0, OP_LOAD, 1, 1, x_dec()));
    prog.push_back(mk(0, OP_LOAD, 1, 1, x_ex(2'b10, 3'b000)));
    prog.push_back(mk(0, OP_LOAD, 1, 1, x_mem(1)));
    prog.push_back(mk(0, OP_LOAD, 1, 1, x_wb(1)));
    prog.push_back(mk(0, OP_STORE, 1, 1, x_fetch(1)));
    prog.push_back(mk(0, OP_STORE, 1, 1, x_dec()));
    prog.push_back(mk(0, OP_STORE, 1, 1, x_ex(2'b10, 3'b000)));
    prog.push_back(mk(0, OP_STORE, 1, 1, x_mem(0)));
    prog.push_back(mk(0, OP_BRANCH, 1, 1, x_fetch(1)));
    prog.push_back(mk(0, OP_BRANCH, 1, 1, x_dec()));
    prog.push_back(mk(0, OP_BRANCH, 1, 1, x_beq(1)));
    prog.push_back(mk(0, OP_BAD, 1, 1, x_fetch(1)));
    prog.push_back(mk(0, OP_BAD, 1, 1, x_dec()));
    prog.push_back(mk(0, OP_BAD, 1, 1, x_halt()));

    // load with three wait cycles in MEM: 8 cycles, then FETCH
    misc.push_back(mk(1, OP_LOAD, 0, 1, x_fetch(1)));
    misc.push_back(mk(0, OP_LOAD, 0, 0, x_dec()));
    misc.push_back(mk(0, OP_LOAD, 0, 0, x_ex(2'b10, 3'b000)));
    misc.push_back(mk(0, OP_LOAD, 0, 0, x_mem(1)));
    misc.push_back(mk(0, OP_LOAD, 0, 0, x_mem(1)));
    misc.push_back(mk(0, OP_LOAD, 0, 0, x_mem(1)));
    misc.push_back(mk(0, OP_LOAD, 0, 1, x_mem(1)));
    misc.push_back(mk(0, OP_LOAD, 0, 0, x_wb(1)));
    misc.push_back(mk(0, OP_LOAD, 0, 0, x_fetch(0)));
    // beq not taken
    misc.push_back(mk(1, OP_BRANCH, 0, 1, x_fetch(1)));
    misc.push_back(mk(0, OP_BRANCH, 0, 1, x_dec()));
    misc.push_back(mk(0, OP_BRANCH, 0, 1, x_beq(0)));
    misc.push_back(mk(0, OP_BRANCH, 0, 0, x_fetch(0)));
    // addi with a fetch wait
    misc.push_back(mk(0, OP_IALU, 0, 1, x_fetch(1)));
    misc.push_back(mk(0, OP_IALU, 0, 1, x_dec()));
    misc.push_back(mk(0, OP_IALU, 0, 1, x_ex(2'b10, 3'b011)));
    misc.push_back(mk(0, OP_IALU, 0, 1, x_wb(0)));
    // store with a wait in MEM
    misc.push_back(mk(0, OP_STORE, 0, 1, x_fetch(1)));
    misc.push_back(mk(0, OP_STORE, 0, 0, x_dec()));
    misc.push_back(mk(0, OP_STORE, 0, 0, x_ex(2'b10, 3'b000)));
    misc.push_back(mk(0, OP_STORE, 0, 0, x_mem(0)));
    misc.push_back(mk(0, OP_STORE, 0, 1, x_mem(0)));
    misc.push_back(mk(0, OP_STORE, 0, 0, x_fetch(0)));

    @(posedge clk); #1;

    foreach (prog[i]) apply(prog[i], $sformatf("prog%0d", i));
`ifdef MC_PERF_COUNTERS_EN
    check("instret", instret, 32'd4);
    check("cycle_count", cycle_count, 32'd17);
    repeat (5) @(posedge clk);
    #1;
    check("instret_frozen", instret, 32'd4);
    check("cycle_frozen", cycle_count, 32'd17);
`endif

    foreach (misc[i]) apply(misc[i], $sformatf("misc%0d", i));

    // reset asserted in the WB cycle of an R-type
    apply(mk(1, OP_R, 0, 1, x_fetch(1)), "rwb_fetch");
    apply(mk(0, OP_R, 0, 1, x_dec()), "rwb_dec");
    apply(mk(0, OP_R, 0, 1, x_ex(2'b00, 3'b010)), "rwb_exec");
    #1 check("rwb_wb_regwrite", {31'd0, reg_write}, 32'd1);
    reset = 1'b1;
    #1 check("rwb_gated", {15'd0, act()}, 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rwb_after_state", {29'd0, state}, 32'd0);
    check("rwb_after_mrd", {31'd0, mem_read}, 32'd1);
    @(posedge clk); #1;

    // X opcode in DECODE halts; HALT ignores everything for 100 cycles
    apply(mk(1, 7'bx, 0, 1, x_fetch(1)), "xop_fetch");
    apply(mk(0, 7'bx, 0, 1, x_dec()), "xop_dec");
    for (int c = 0; c < 100; c++) begin
      mem_ready = 1'($urandom);
      zero = 1'($urandom);
      opcode = (c % 2 == 0) ? OP_LOAD : OP_STORE;
      @(negedge clk);
      check($sformatf("halt%0d", c), {15'd0, act()},
            {15'd0, x_halt()});
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
